// File: rtl/ex_alu_unit_pkg.sv
// Shared encodings for the execute-stage ALU block.
// The control unit imports the same ALU opcodes and branch types.
package ex_alu_unit_pkg;

    // ALU operation select (alu_ctrl)
    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_ADDU = 4'b0011;
    localparam logic [3:0] ALU_SUB  = 4'b0100;
    localparam logic [3:0] ALU_SUBU = 4'b0101;
    localparam logic [3:0] ALU_XOR  = 4'b0110;
    localparam logic [3:0] ALU_NOR  = 4'b0111;
    localparam logic [3:0] ALU_SLT  = 4'b1000;
    localparam logic [3:0] ALU_SLTU = 4'b1001;
    localparam logic [3:0] ALU_SLL  = 4'b1010;
    localparam logic [3:0] ALU_SRL  = 4'b1011;
    localparam logic [3:0] ALU_SRA  = 4'b1100;
    localparam logic [3:0] ALU_LUI  = 4'b1101;

    // Branch type of the instruction in ID/EX; 2'b11 is reserved but still a branch
    localparam logic [1:0] BR_NONE = 2'b00;
    localparam logic [1:0] BR_BEQ  = 2'b01;
    localparam logic [1:0] BR_BNE  = 2'b10;

    // Any non-NONE code, including the reserved one, counts as a branch
    function automatic logic is_branch(input logic [1:0] br);
        return br != BR_NONE;
    endfunction

endpackage

// File: rtl/ex_alu_unit_if.sv
// Signal bundle between the execute stage and the ALU block.
// master drives operands/controls, slave (the ALU block) drives results.
interface ex_alu_unit_if #(
    parameter int DATA_W = 32
);
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [3:0]        alu_ctrl;
    logic [DATA_W-1:0] alu_result;
    logic              alu_zero;
    logic              alu_ovf;
    logic              ovf_sticky;
    logic [DATA_W-1:0] add_a;
    logic [DATA_W-1:0] add_b;
    logic [DATA_W-1:0] add_sum;
    logic [1:0]        id_ex_branch;
    logic              id_ex_pc_src;
    logic              delay;

    modport master (
        output alu_a, alu_b, alu_ctrl, add_a, add_b, id_ex_branch, id_ex_pc_src,
        input  alu_result, alu_zero, alu_ovf, ovf_sticky, add_sum, delay
    );

    modport slave (
        input  alu_a, alu_b, alu_ctrl, add_a, add_b, id_ex_branch, id_ex_pc_src,
        output alu_result, alu_zero, alu_ovf, ovf_sticky, add_sum, delay
    );
endinterface

// File: rtl/ex_add32.sv
// Plain modulo-2^W adder with carry-in; carry-out is intentionally dropped.
module ex_add32 #(
    parameter int W = 32
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         cin_i,
    output logic [W-1:0] sum_o
);
    // Wrap-around is silent: the sum is truncated to W bits
    assign sum_o = a_i + b_i + W'(cin_i);
endmodule

// File: rtl/ex_alu_unit.sv
// Execute-stage arithmetic: main ALU, free-standing PC adder, branch-delay
// detection and a sticky signed-overflow flag (the only state).
module ex_alu_unit
    import ex_alu_unit_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int SHAMT_W = 5
) (
    input  logic          clk,
    input  logic          rst,
    ex_alu_unit_if.slave  bus
);
    localparam int MSB = DATA_W - 1;

    logic              is_sub;
    logic [DATA_W-1:0] addsub_b;
    logic [DATA_W-1:0] addsub_res;
    logic [SHAMT_W-1:0] shamt;
    logic [DATA_W-1:0] sra_res;
    logic              slt_lt;
    logic              sltu_lt;
    logic              add_ovf;
    logic              sub_ovf;
    logic [DATA_W-1:0] result;
    logic              ovf;
    logic              ovf_sticky_q;
    logic              ovf_sticky_d;

    // Subtraction reuses the adder as a + ~b + 1
    assign is_sub   = (bus.alu_ctrl == ALU_SUB) || (bus.alu_ctrl == ALU_SUBU);
    assign addsub_b = is_sub ? ~bus.alu_b : bus.alu_b;

    ex_add32 #(.W(DATA_W)) u_alu_add (
        .a_i   (bus.alu_a),
        .b_i   (addsub_b),
        .cin_i (is_sub),
        .sum_o (addsub_res)
    );

    // Free-standing adder for PC+4 / branch target
    ex_add32 #(.W(DATA_W)) u_pc_add (
        .a_i   (bus.add_a),
        .b_i   (bus.add_b),
        .cin_i (1'b0),
        .sum_o (bus.add_sum)
    );

    // Only the low shift-amount bits of A select the shift distance
    assign shamt   = bus.alu_a[SHAMT_W-1:0];
    assign sra_res = $signed(bus.alu_b) >>> shamt;
    assign slt_lt  = $signed(bus.alu_a) < $signed(bus.alu_b);
    assign sltu_lt = bus.alu_a < bus.alu_b;

    // Signed overflow: sign of the wrapped result disagrees with what the operands allow
    assign add_ovf = (bus.alu_a[MSB] == bus.alu_b[MSB]) && (addsub_res[MSB] != bus.alu_a[MSB]);
    assign sub_ovf = (bus.alu_a[MSB] != bus.alu_b[MSB]) && (addsub_res[MSB] != bus.alu_a[MSB]);

    // Operation select; reserved opcodes yield zero so alu_zero reads 1
    always_comb begin
        // NOTE: defaults first so every path assigns every output and no latch is inferred.
        result = '0;
        ovf    = 1'b0;
        unique case (bus.alu_ctrl)
            ALU_AND:  result = bus.alu_a & bus.alu_b;
            ALU_OR:   result = bus.alu_a | bus.alu_b;
            ALU_ADD:  begin result = addsub_res; ovf = add_ovf; end
            ALU_ADDU: result = addsub_res;
            ALU_SUB:  begin result = addsub_res; ovf = sub_ovf; end
            ALU_SUBU: result = addsub_res;
            ALU_XOR:  result = bus.alu_a ^ bus.alu_b;
            ALU_NOR:  result = ~(bus.alu_a | bus.alu_b);
            ALU_SLT:  result = {{(DATA_W-1){1'b0}}, slt_lt};
            ALU_SLTU: result = {{(DATA_W-1){1'b0}}, sltu_lt};
            ALU_SLL:  result = bus.alu_b << shamt;
            ALU_SRL:  result = bus.alu_b >> shamt;
            ALU_SRA:  result = sra_res;
            ALU_LUI:  result = {bus.alu_b[15:0], {(DATA_W-16){1'b0}}};
            default:  result = '0;
        endcase
    end

    assign bus.alu_result = result;
    assign bus.alu_zero   = (result == '0);
    assign bus.alu_ovf    = ovf;

    // A taken branch of any type in ID/EX signals a delay to the hazard unit
    assign bus.delay = is_branch(bus.id_ex_branch) & bus.id_ex_pc_src;

    assign ovf_sticky_d = ovf_sticky_q | ovf;

    // Sticky overflow register; reset wins over a simultaneous overflow
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignment for clocked state avoids simulation races between flops.
        if (rst) begin
            ovf_sticky_q <= 1'b0;
        end else begin
            ovf_sticky_q <= ovf_sticky_d;
        end
    end

    assign bus.ovf_sticky = ovf_sticky_q;

endmodule

// File: tb/tb_ex_alu_unit.sv
// Self-checking bench for ex_alu_unit: directed vector tables, hand-written
// sticky-flag sequence, and randomized checks against an arithmetic model.
module tb_ex_alu_unit;
    import ex_alu_unit_pkg::*;

    logic clk;
    logic rst;
    int   pass_cnt;
    int   total_cnt;

    ex_alu_unit_if #(.DATA_W(32)) bus ();

    ex_alu_unit #(.DATA_W(32), .SHAMT_W(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  ctrl;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_res;
        logic        exp_zero;
        logic        exp_ovf;
    } alu_vec_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_sum;
    } add_vec_t;

    typedef struct {
        logic [1:0] br;
        logic       pc_src;
        logic       exp_delay;
    } br_vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    // Reference ALU from arithmetic definitions on 64-bit integers
    function automatic void ref_alu(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] r, output logic ovf);
        longint sa, sb, ua, ub, s, p;
        int sh;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        sh = int'(a % 32);
        p  = longint'(1) << sh;
        r   = '0;
        ovf = 1'b0;
        s   = 0;
        case (c)
            4'd0:  r = a & b;
            4'd1:  r = a | b;
            4'd2:  begin s = sa + sb; r = s[31:0];
                         ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
            4'd3:  begin s = ua + ub; r = s[31:0]; end
            4'd4:  begin s = sa - sb; r = s[31:0];
                         ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
            4'd5:  begin s = ua - ub; r = s[31:0]; end
            4'd6:  r = a ^ b;
            4'd7:  r = ~(a | b);
            4'd8:  r = (sa < sb) ? 32'd1 : 32'd0;
            4'd9:  r = (ua < ub) ? 32'd1 : 32'd0;
            4'd10: begin s = ub * p; r = s[31:0]; end
            4'd11: begin s = ub / p; r = s[31:0]; end
            4'd12: begin
                       if (sb >= 0) s = sb / p;
                       else         s = -((-sb + p - 1) / p);
                       r = s[31:0];
                   end
            4'd13: begin s = (ub % 65536) * 65536; r = s[31:0]; end
            default: r = '0;
        endcase
    endfunction

    task automatic drive_alu(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        bus.alu_ctrl = c;
        bus.alu_a    = a;
        bus.alu_b    = b;
    endtask

    alu_vec_t alu_tbl[$];
    add_vec_t add_tbl[$];
    br_vec_t  br_tbl[$];

    initial begin
        logic [31:0] r_exp;
        logic        o_exp;
        logic        model_sticky;

        pass_cnt  = 0;
        total_cnt = 0;

        alu_tbl = '{
            '{ALU_ADD,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1},
            '{ALU_ADDU, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b0},
            '{ALU_SUB,  32'h00000005, 32'h00000005, 32'h00000000, 1'b1, 1'b0},
            '{ALU_SUB,  32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b0, 1'b1},
            '{ALU_SUB,  32'h00000000, 32'h80000000, 32'h80000000, 1'b0, 1'b1},
            '{ALU_SUBU, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1'b0, 1'b0},
            '{ALU_SLT,  32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1'b0},
            '{ALU_SLTU, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0},
            '{ALU_SLL,  32'd31,       32'h00000001, 32'h80000000, 1'b0, 1'b0},
            '{ALU_SRL,  32'd4,        32'h80000000, 32'h08000000, 1'b0, 1'b0},
            '{ALU_SRA,  32'd4,        32'h80000000, 32'hF8000000, 1'b0, 1'b0},
            '{ALU_SLL,  32'h00000025, 32'h00000001, 32'h00000020, 1'b0, 1'b0},
            '{ALU_LUI,  32'h00000000, 32'h00001234, 32'h12340000, 1'b0, 1'b0},
            '{ALU_AND,  32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 1'b0, 1'b0},
            '{ALU_OR,   32'hF0F0F0F0, 32'h0FF00FF0, 32'hFFF0FFF0, 1'b0, 1'b0},
            '{ALU_XOR,  32'hF0F0F0F0, 32'h0FF00FF0, 32'hFF00FF00, 1'b0, 1'b0},
            '{ALU_NOR,  32'hF0F0F0F0, 32'h0FF00FF0, 32'h000F000F, 1'b0, 1'b0},
            '{4'b1111,  32'hF0F0F0F0, 32'h0FF00FF0, 32'h00000000, 1'b1, 1'b0},
            '{4'b1110,  32'h7FFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0}
        };
        add_tbl = '{
            '{32'h00000100, 32'h00000004, 32'h00000104},
            '{32'hFFFFFFFC, 32'h00000004, 32'h00000000},
            '{32'h00400010, 32'hFFFFFFF0, 32'h00400000}
        };
        br_tbl = '{
            '{BR_BEQ,  1'b1, 1'b1},
            '{BR_BNE,  1'b1, 1'b1},
            '{BR_NONE, 1'b1, 1'b0},
            '{BR_BEQ,  1'b0, 1'b0},
            '{2'b11,   1'b1, 1'b1},
            '{2'b11,   1'b0, 1'b0}
        };

        // Reset with a benign operation applied
        rst = 1'b1;
        drive_alu(ALU_AND, 32'h0, 32'h0);
        bus.add_a        = '0;
        bus.add_b        = '0;
        bus.id_ex_branch = BR_NONE;
        bus.id_ex_pc_src = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset sticky", {31'd0, bus.ovf_sticky}, 32'd0);
        rst = 1'b0;

        // Directed ALU vectors (combinational)
        foreach (alu_tbl[i]) begin
            drive_alu(alu_tbl[i].ctrl, alu_tbl[i].a, alu_tbl[i].b);
            #1;
            check($sformatf("alu%0d result", i), bus.alu_result, alu_tbl[i].exp_res);
            check($sformatf("alu%0d zero", i), {31'd0, bus.alu_zero}, {31'd0, alu_tbl[i].exp_zero});
            check($sformatf("alu%0d ovf", i), {31'd0, bus.alu_ovf}, {31'd0, alu_tbl[i].exp_ovf});
        end

        foreach (add_tbl[i]) begin
            bus.add_a = add_tbl[i].a;
            bus.add_b = add_tbl[i].b;
            #1;
            check($sformatf("add%0d sum", i), bus.add_sum, add_tbl[i].exp_sum);
        end

        foreach (br_tbl[i]) begin
            bus.id_ex_branch = br_tbl[i].br;
            bus.id_ex_pc_src = br_tbl[i].pc_src;
            #1;
            check($sformatf("br%0d delay", i), {31'd0, bus.delay}, {31'd0, br_tbl[i].exp_delay});
        end

        // Sticky flag sequence: reset, no-overflow hold, set, reset priority, release
        @(posedge clk); #1;
        rst = 1'b1;
        drive_alu(ALU_ADD, 32'h1, 32'h1);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check("sticky holds 0 without ovf", {31'd0, bus.ovf_sticky}, 32'd0);
        drive_alu(ALU_ADDU, 32'h7FFFFFFF, 32'h1);
        @(posedge clk); #1;
        check("sticky ADDU no set", {31'd0, bus.ovf_sticky}, 32'd0);
        drive_alu(ALU_ADD, 32'h7FFFFFFF, 32'h1);
        #1;
        check("sticky before edge", {31'd0, bus.ovf_sticky}, 32'd0);
        @(posedge clk); #1;
        check("sticky set by ADD ovf", {31'd0, bus.ovf_sticky}, 32'd1);
        drive_alu(ALU_AND, 32'h0, 32'h0);
        @(posedge clk); #1;
        check("sticky persists", {31'd0, bus.ovf_sticky}, 32'd1);
        drive_alu(ALU_ADD, 32'h7FFFFFFF, 32'h1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("rst beats ovf", {31'd0, bus.ovf_sticky}, 32'd0);
        rst = 1'b0;
        drive_alu(ALU_ADD, 32'h1, 32'h1);
        @(posedge clk); #1;
        check("sticky after release", {31'd0, bus.ovf_sticky}, 32'd0);
        @(posedge clk); #1;
        check("sticky after release 2", {31'd0, bus.ovf_sticky}, 32'd0);

        // Randomized checks against the reference model, tracking sticky state
        model_sticky = 1'b0;
        for (int n = 0; n < 300; n++) begin
            logic [3:0]  c;
            logic [31:0] a, b, aa, ab;
            c = 4'($urandom_range(0, 15));
            a = $urandom();
            b = $urandom();
            if ($urandom_range(0, 3) == 0) a = {a[31], 31'h7FFFFFFF};
            if ($urandom_range(0, 3) == 0) b = {b[31], 31'h00000000};
            if (n % 60 == 59) c = ALU_ADD;
            drive_alu(c, a, b);
            aa = $urandom();
            ab = $urandom();
            bus.add_a        = aa;
            bus.add_b        = ab;
            bus.id_ex_branch = 2'($urandom_range(0, 3));
            bus.id_ex_pc_src = 1'($urandom_range(0, 1));
            #1;
            ref_alu(c, a, b, r_exp, o_exp);
            check($sformatf("rnd%0d ctrl%0d result", n, c), bus.alu_result, r_exp);
            check($sformatf("rnd%0d zero", n), {31'd0, bus.alu_zero}, {31'd0, r_exp == 32'd0});
            check($sformatf("rnd%0d ovf", n), {31'd0, bus.alu_ovf}, {31'd0, o_exp});
            check($sformatf("rnd%0d sum", n), bus.add_sum, 32'((longint'(aa) + longint'(ab)) % 64'sd4294967296));
            check($sformatf("rnd%0d delay", n), {31'd0, bus.delay},
                  {31'd0, (bus.id_ex_branch != 2'b00) && bus.id_ex_pc_src});
            check($sformatf("rnd%0d sticky", n), {31'd0, bus.ovf_sticky}, {31'd0, model_sticky});
            model_sticky = model_sticky | o_exp;
            @(posedge clk); #1;
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
